// File: rtl/dma_gic_irq_pkg.sv
// rtl/dma_gic_irq_pkg.sv - shared types and constants for the DMA-to-GIC interrupt generator
package dma_gic_irq_pkg;

   localparam int N_IRQ = 3;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCUM  = 2'd1,
      ASSERT = 2'd2,
      GAP    = 2'd3
   } irq_st_e;

endpackage

// File: rtl/dma_gic_irq_gen_if.sv
// rtl/dma_gic_irq_gen_if.sv - 3-line DMA-to-GIC interrupt bundle
interface dma_pcie_gic_if;
   import dma_gic_irq_pkg::*;

   logic [N_IRQ-1:0] interrupt;

   modport m (output interrupt);
   modport s (input  interrupt);

endinterface

// File: rtl/dma_gic_irq_chan.sv
// rtl/dma_gic_irq_chan.sv - one interrupt line: coalescing FSM, event counter, timer, re-fire gap
module dma_gic_irq_chan
   import dma_gic_irq_pkg::*;
#(
   parameter int CNT_W   = 8,
   parameter int TMR_W   = 16,
   parameter int MIN_GAP = 4
) (
   input  logic             user_clk,
   input  logic             user_reset_n,
   input  logic             evt,
   input  logic             mask,
   input  logic             ack,
   input  logic [CNT_W-1:0] coal_thresh,
   input  logic [TMR_W-1:0] coal_timeout,
   output logic             irq,
   output logic             status,
   output logic [CNT_W-1:0] cnt
);

   localparam int GAP_W = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;

   irq_st_e          st_q, st_d;
   logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
   logic [TMR_W-1:0] tmr_q, tmr_d, tmr_inc;
   logic [TMR_W:0]   tmr_p1;
   logic [GAP_W-1:0] gap_q, gap_d;
   logic             pend_q, pend_d, pend_any;
   logic             irq_q, irq_d;
   logic             fire_now;

   always_ff @(posedge user_clk) begin
      if (!user_reset_n) begin
         st_q   <= IDLE;
         cnt_q  <= '0;
         tmr_q  <= '0;
         gap_q  <= '0;
         pend_q <= 1'b0;
         irq_q  <= 1'b0;
      end else begin
         st_q   <= st_d;
         cnt_q  <= cnt_d;
         tmr_q  <= tmr_d;
         gap_q  <= gap_d;
         pend_q <= pend_d;
         irq_q  <= irq_d;
      end
   end

   always_comb begin
      st_d     = st_q;
      cnt_d    = cnt_q;
      tmr_d    = tmr_q;
      gap_d    = gap_q;
      pend_d   = pend_q;
      cnt_inc  = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
      tmr_inc  = (&tmr_q) ? tmr_q : tmr_q + TMR_W'(1);
      tmr_p1   = {1'b0, tmr_q} + (TMR_W+1)'(1);
      fire_now = (coal_thresh <= CNT_W'(1));
      pend_any = pend_q | evt;

      case (st_q)
         IDLE: begin
            if (evt) begin
               cnt_d  = CNT_W'(1);
               // The event cycle itself counts, so coal_timeout is measured from the first event.
               tmr_d  = TMR_W'(1);
               pend_d = 1'b0;
               st_d   = fire_now ? ASSERT : ACCUM;
            end
         end
         ACCUM: begin
            tmr_d = tmr_inc;
            if (evt) cnt_d = cnt_inc;
            if ((cnt_d >= coal_thresh) ||
                ((coal_timeout != '0) && (tmr_p1 >= {1'b0, coal_timeout}))) begin
               st_d = ASSERT;
            end
         end
         ASSERT: begin
            if (ack) begin
               st_d   = GAP;
               cnt_d  = pend_any ? CNT_W'(1) : '0;
               pend_d = pend_any;
               gap_d  = GAP_W'(MIN_GAP - 1);
            end else if (evt) begin
               pend_d = 1'b1;
               cnt_d  = cnt_inc;
            end
         end
         GAP: begin
            if (gap_q == '0) begin
               pend_d = 1'b0;
               if (pend_any) begin
                  cnt_d = CNT_W'(1);
                  tmr_d = '0;
                  st_d  = fire_now ? ASSERT : ACCUM;
               end else begin
                  st_d  = IDLE;
               end
            end else begin
               gap_d  = gap_q - GAP_W'(1);
               pend_d = pend_any;
            end
         end
         default: st_d = IDLE;
      endcase

      irq_d = (st_d == ASSERT) && !mask;
   end

   assign irq    = irq_q;
   assign status = (st_q == ASSERT);
   assign cnt    = cnt_q;

endmodule

// File: rtl/dma_gic_irq_gen.sv
// rtl/dma_gic_irq_gen.sv - DMA event coalescing interrupt generator driving the GIC bundle
module dma_gic_irq_gen
   import dma_gic_irq_pkg::*;
#(
   parameter int CNT_W   = 8,
   parameter int TMR_W   = 16,
   parameter int MIN_GAP = 4
) (
   input  logic                   user_clk,
   input  logic                   user_reset_n,
   input  logic [N_IRQ-1:0]       evt,
   input  logic [N_IRQ-1:0]       irq_mask,
   input  logic [CNT_W-1:0]       coal_thresh,
   input  logic [TMR_W-1:0]       coal_timeout,
   input  logic [N_IRQ-1:0]       ack,
   output logic [N_IRQ-1:0]       status,
   output logic [N_IRQ*CNT_W-1:0] evt_cnt,
   dma_pcie_gic_if.m              gic
);

   logic [N_IRQ-1:0] irq;

   for (genvar i = 0; i < N_IRQ; i++) begin : g_chan
      dma_gic_irq_chan #(
         .CNT_W   (CNT_W),
         .TMR_W   (TMR_W),
         .MIN_GAP (MIN_GAP)
      ) u_chan (
         .user_clk     (user_clk),
         .user_reset_n (user_reset_n),
         .evt          (evt[i]),
         .mask         (irq_mask[i]),
         .ack          (ack[i]),
         .coal_thresh  (coal_thresh),
         .coal_timeout (coal_timeout),
         .irq          (irq[i]),
         .status       (status[i]),
         .cnt          (evt_cnt[i*CNT_W +: CNT_W])
      );
   end

   assign gic.interrupt = irq;

endmodule
